esc_halfduplex_uart: RTL and testbench

ESC_HALFDUPLEX_UART -- requirements
Module: esc_halfduplex_uart

---
 rtl/esc_halfduplex_uart.sv | 335 +++++++++++++++++++++++++++++++++
 tb/tb_esc_halfduplex_uart.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/esc_halfduplex_uart.sv
// Half-duplex 8N1 UART bridging a USB byte stream onto a single-wire ESC motor pin.
// TX owns the wire while framing and guarding; RX listens only while TX is idle.
module esc_halfduplex_uart #(
    parameter int unsigned CLK_FREQ_HZ = 72000000,
    parameter int unsigned BAUD_RATE   = 19200,
    parameter int unsigned GUARD_BITS  = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    input  logic       i_rx_ready,
    output logic       o_line_out,
    output logic       o_line_oe,
    input  logic       i_line_in,
    output logic       o_rx_overrun,
    output logic       o_busy
);

    localparam int unsigned BIT_CYC  = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned HALF_CYC = BIT_CYC / 2;
    localparam int unsigned HOLD_CYC = GUARD_BITS * BIT_CYC;
    localparam int unsigned CNT_MAX  = (HOLD_CYC > BIT_CYC) ? HOLD_CYC : BIT_CYC;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        TX_HOLD
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // ------------------------------------------------------------------
    // TX byte FIFO (extra pointer bit distinguishes full from empty)
    // ------------------------------------------------------------------
    logic [7:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           fifo_empty;
    logic           fifo_full;
    logic           fifo_push;
    logic           tx_pop;
    logic           run_q;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign o_tx_ready = run_q && i_enable && !fifo_full;
    assign fifo_push  = i_tx_valid && o_tx_ready;

    // run_q holds ready low until the first edge after reset release
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (!i_enable) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (tx_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= i_tx_data;
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    tx_state_t        tx_state;
    tx_state_t        tx_state_d;
    logic [CNT_W-1:0] tx_cnt;
    logic [CNT_W-1:0] tx_cnt_d;
    logic [2:0]       tx_bit;
    logic [2:0]       tx_bit_d;
    logic [7:0]       tx_byte;
    logic [7:0]       tx_byte_d;
    logic             line_oe_d;
    logic             line_out_d;
    logic             tx_launch;
    rx_state_t        rx_state;

    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt + 1'b1;
        tx_bit_d   = tx_bit;
        tx_byte_d  = tx_byte;
        tx_pop     = 1'b0;
        line_oe_d  = 1'b0;
        line_out_d = 1'b1;

        case (tx_state)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (!fifo_empty && (rx_state == RX_IDLE)) begin
                    tx_pop     = 1'b1;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_d = '0;
                    tx_bit_d = tx_bit + 1'b1;
                    if (tx_bit == 3'd7) begin
                        tx_state_d = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (!fifo_empty) begin
                        tx_pop     = 1'b1;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_HOLD;
                    end
                end
            end
            TX_HOLD: begin
                if (!fifo_empty) begin
                    tx_cnt_d   = '0;
                    tx_pop     = 1'b1;
                    tx_state_d = TX_START;
                end else if (tx_cnt == HOLD_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                end
            end
            default: begin
                tx_cnt_d   = '0;
                tx_state_d = TX_IDLE;
            end
        endcase

        if (tx_pop) begin
            tx_byte_d = fifo_mem[rd_ptr[PTR_W-1:0]];
        end

        // Disable abandons any frame in flight and releases the wire
        if (!i_enable) begin
            tx_state_d = TX_IDLE;
            tx_cnt_d   = '0;
            tx_pop     = 1'b0;
        end

        // Pin drive is derived from the state being entered so it changes with the pop
        line_oe_d = (tx_state_d != TX_IDLE);
        case (tx_state_d)
            TX_START: line_out_d = 1'b0;
            TX_DATA:  line_out_d = tx_byte_d[tx_bit_d];
            default:  line_out_d = 1'b1;
        endcase
    end

    assign tx_launch = (tx_state == TX_IDLE) && tx_pop;
    assign o_busy    = (tx_state != TX_IDLE) || !fifo_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_state   <= TX_IDLE;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_byte    <= '0;
            o_line_oe  <= 1'b0;
            o_line_out <= 1'b1;
        end else begin
            tx_state   <= tx_state_d;
            tx_cnt     <= tx_cnt_d;
            tx_bit     <= tx_bit_d;
            tx_byte    <= tx_byte_d;
            o_line_oe  <= line_oe_d;
            o_line_out <= line_out_d;
        end
    end

    // ------------------------------------------------------------------
    // RX path: pin synchronizer, own echo masked while driving
    // ------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       rx_bit;
    logic       rx_active;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_line_in};
        end
    end

    assign rx_bit    = o_line_oe ? 1'b1 : sync_q[1];
    assign rx_active = i_enable && (tx_state == TX_IDLE) && !tx_launch;

    rx_state_t        rx_state_d;
    logic [CNT_W-1:0] rx_cnt;
    logic [CNT_W-1:0] rx_cnt_d;
    logic [2:0]       rx_idx;
    logic [2:0]       rx_idx_d;
    logic [7:0]       rx_shift;
    logic [7:0]       rx_shift_d;
    logic             rx_done;

    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt + 1'b1;
        rx_idx_d   = rx_idx;
        rx_shift_d = rx_shift;
        rx_done    = 1'b0;

        case (rx_state)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_bit) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_d = '0;
                    rx_idx_d = '0;
                    rx_state_d = rx_bit ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_bit, rx_shift[7:1]};
                    rx_idx_d   = rx_idx + 1'b1;
                    if (rx_idx == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_done    = rx_bit;
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_cnt_d   = '0;
                rx_state_d = RX_IDLE;
            end
        endcase

        if (!rx_active) begin
            rx_state_d = RX_IDLE;
            rx_cnt_d   = '0;
            rx_done    = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_d;
            rx_cnt   <= rx_cnt_d;
            rx_idx   <= rx_idx_d;
            rx_shift <= rx_shift_d;
        end
    end

    // Output holding register; a byte completing while the old one is stuck is dropped
    logic rx_consume;
    assign rx_consume = o_rx_valid && i_rx_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rx_data    <= '0;
            o_rx_valid   <= 1'b0;
            o_rx_overrun <= 1'b0;
        end else if (!i_enable) begin
            o_rx_valid   <= 1'b0;
            o_rx_overrun <= 1'b0;
        end else if (rx_done && (!o_rx_valid || rx_consume)) begin
            o_rx_data  <= rx_shift;
            o_rx_valid <= 1'b1;
        end else begin
            if (rx_consume) begin
                o_rx_valid <= 1'b0;
            end
            if (rx_done) begin
                o_rx_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_esc_halfduplex_uart.sv
// Bench for esc_halfduplex_uart: frame-level line model plus directed literal checks.
module tb_esc_halfduplex_uart;

    localparam int unsigned CLK_HZ = 160;
    localparam int unsigned BAUD   = 10;
    localparam int          B      = 16;
    localparam int          G      = 2;
    localparam int          DEPTH  = 4;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_enable;
    logic [7:0] i_tx_data;
    logic       i_tx_valid;
    logic       o_tx_ready;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       i_rx_ready;
    logic       o_line_out;
    logic       o_line_oe;
    logic       i_line_in;
    logic       o_rx_overrun;
    logic       o_busy;

    int checks = 0;
    int errors = 0;

    esc_halfduplex_uart #(
        .CLK_FREQ_HZ(CLK_HZ),
        .BAUD_RATE  (BAUD),
        .GUARD_BITS (G),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_enable    (i_enable),
        .i_tx_data   (i_tx_data),
        .i_tx_valid  (i_tx_valid),
        .o_tx_ready  (o_tx_ready),
        .o_rx_data   (o_rx_data),
        .o_rx_valid  (o_rx_valid),
        .i_rx_ready  (i_rx_ready),
        .o_line_out  (o_line_out),
        .o_line_oe   (o_line_oe),
        .i_line_in   (i_line_in),
        .o_rx_overrun(o_rx_overrun),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Line model: a frame is 10 bit-times, guard follows only when nothing queued
    // ------------------------------------------------------------------
    logic [7:0] m_q[$];
    int         m_fc   = -1;
    int         m_hold = 0;
    logic [7:0] m_cur  = '0;
    logic       m_run  = 1'b0;
    logic       en_rec = 1'b0;
    logic       rst_rec = 1'b0;
    logic       push_rec = 1'b0;
    logic [7:0] push_byte = '0;

    logic [7:0] exp_rx [16];
    int         exp_wr = 0;
    int         exp_rd = 0;
    int         oe_cnt = 0;

    function automatic logic frame_bit(input int fc, input logic [7:0] b);
        int k;
        k = fc / B;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    always @(negedge i_clk) begin
        logic exp_oe, exp_out, exp_busy, exp_ready;
        // advance the model over the posedge that just happened
        if (!i_rst_n || !rst_rec) begin
            m_q.delete(); m_fc = -1; m_hold = 0; m_run = 1'b0;
        end else if (!en_rec) begin
            m_q.delete(); m_fc = -1; m_hold = 0; m_run = 1'b1;
        end else begin
            m_run = 1'b1;
            if (m_fc >= 0) begin
                m_fc++;
                if (m_fc == 10*B) begin
                    if (m_q.size() > 0) begin
                        m_cur = m_q.pop_front(); m_fc = 0;
                    end else begin
                        m_fc = -1; m_hold = G*B;
                    end
                end
            end else if (m_hold > 0) begin
                if (m_q.size() > 0) begin
                    m_cur = m_q.pop_front(); m_fc = 0; m_hold = 0;
                end else begin
                    m_hold--;
                end
            end else if (m_q.size() > 0) begin
                m_cur = m_q.pop_front(); m_fc = 0;
            end
            if (push_rec) m_q.push_back(push_byte);
        end

        exp_oe    = (m_fc >= 0) || (m_hold > 0);
        exp_out   = (m_fc >= 0) ? frame_bit(m_fc, m_cur) : 1'b1;
        exp_busy  = exp_oe || (m_q.size() > 0);
        exp_ready = m_run && i_enable && (m_q.size() < DEPTH);

        chk("line_oe",  {31'd0, o_line_oe},  {31'd0, exp_oe});
        chk("line_out", {31'd0, o_line_out}, {31'd0, exp_out});
        chk("busy",     {31'd0, o_busy},     {31'd0, exp_busy});
        chk("tx_ready", {31'd0, o_tx_ready}, {31'd0, exp_ready});

        if (!i_rst_n) begin
            chk("rst_rx_valid", {31'd0, o_rx_valid},   32'd0);
            chk("rst_rx_data",  {24'd0, o_rx_data},    32'd0);
            chk("rst_overrun",  {31'd0, o_rx_overrun}, 32'd0);
        end else if (i_enable && o_rx_valid && i_rx_ready) begin
            if (exp_rd >= exp_wr) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got byte %0h expected none at %0t", o_rx_data, $time);
            end else begin
                chk("rx_data", {24'd0, o_rx_data}, {24'd0, exp_rx[exp_rd]});
                exp_rd++;
            end
        end

        if (o_line_oe) oe_cnt++;

        push_rec  = i_tx_valid && exp_ready;
        push_byte = i_tx_data;
        en_rec    = i_enable;
        rst_rec   = i_rst_n;
    end

    // ------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------
    task automatic push(input logic [7:0] d);
        int n;
        n = 0;
        i_tx_data  = d;
        i_tx_valid = 1'b1;
        @(negedge i_clk);
        while (!o_tx_ready && n < 2000) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 2000) chk("push_timeout", 32'd1, 32'd0);
        @(posedge i_clk);
        #1;
        i_tx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        logic [9:0] f;
        f = {stop_b, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            i_line_in = f[i];
            repeat (B) @(posedge i_clk);
            #1;
        end
        i_line_in = 1'b1;
        repeat (2*B) @(posedge i_clk);
        #1;
    endtask

    task automatic expect_rx(input logic [7:0] d);
        exp_rx[exp_wr] = d;
        exp_wr++;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Call right after a push into an idle transmitter
    task automatic tx_watch(input logic [9:0] bits, input string tag);
        @(negedge i_clk);
        chk({tag, "_oe_before_pop"}, {31'd0, o_line_oe}, 32'd0);
        @(negedge i_clk);
        chk({tag, "_oe_at_pop"}, {31'd0, o_line_oe}, 32'd1);
        for (int i = 1; i <= 12*B; i++) begin
            @(negedge i_clk);
            if (i < 10*B && (i % B) == B/2)
                chk({tag, "_bit"}, {31'd0, o_line_out}, {31'd0, bits[i/B]});
            if (i == 12*B-1) chk({tag, "_oe_last"}, {31'd0, o_line_oe}, 32'd1);
            if (i == 12*B)   chk({tag, "_oe_drop"}, {31'd0, o_line_oe}, 32'd0);
        end
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        i_rst_n = 1'b0; i_enable = 1'b0; i_tx_valid = 1'b0; i_tx_data = '0;
        i_rx_ready = 1'b1; i_line_in = 1'b1;
        cycles(3);

        @(negedge i_clk);
        chk("reset_oe",    {31'd0, o_line_oe},  32'd0);
        chk("reset_out",   {31'd0, o_line_out}, 32'd1);
        chk("reset_ready", {31'd0, o_tx_ready}, 32'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1; i_enable = 1'b1;
        @(negedge i_clk);
        chk("ready_before_edge", {31'd0, o_tx_ready}, 32'd0);
        @(negedge i_clk);
        chk("ready_after_edge", {31'd0, o_tx_ready}, 32'd1);
        cycles(2);

        // single frame 0xA5: 0,1,0,1,0,0,1,0,1,1 then guard
        push(8'hA5);
        tx_watch(10'b11_0100_1010, "a5");
        cycles(4);

        // five back-to-back frames through a 4-deep FIFO
        base = oe_cnt;
        push(8'h10); push(8'h21); push(8'h32); push(8'h43); push(8'h54);
        @(negedge i_clk);
        chk("ready_full", {31'd0, o_tx_ready}, 32'd0);
        n = 0;
        while (o_line_oe && n < 2000) begin @(negedge i_clk); n++; end
        chk("burst_oe_cycles", oe_cnt - base, 32'd832);
        cycles(4);

        // RX 0x3C then a short glitch
        send_frame_checked();

        // overrun: 0x11 held, 0x22 dropped
        i_rx_ready = 1'b0;
        expect_rx(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        chk("ovr_data",  {24'd0, o_rx_data},    32'h11);
        chk("ovr_valid", {31'd0, o_rx_valid},   32'd1);
        chk("ovr_flag",  {31'd0, o_rx_overrun}, 32'd1);
        send_frame(8'h33, 1'b0);
        chk("ferr_data", {24'd0, o_rx_data},    32'h11);
        chk("ferr_flag", {31'd0, o_rx_overrun}, 32'd1);
        i_rx_ready = 1'b1;
        cycles(3);
        chk("ovr_consumed", {31'd0, o_rx_valid}, 32'd0);
        send_frame(8'h44, 1'b0);
        chk("ferr_no_byte", exp_rd, 32'd2);
        i_enable = 1'b0;
        cycles(1);
        i_enable = 1'b1;
        @(negedge i_clk);
        chk("ovr_cleared", {31'd0, o_rx_overrun}, 32'd0);
        cycles(4);

        // disable mid-DATA of 0x55 with 0x77 queued, then clean restart
        push(8'h55); push(8'h77);
        cycles(3*B);
        i_enable = 1'b0;
        @(negedge i_clk);
        chk("dis_ready", {31'd0, o_tx_ready}, 32'd0);
        @(negedge i_clk);
        chk("dis_oe",   {31'd0, o_line_oe}, 32'd0);
        chk("dis_busy", {31'd0, o_busy},    32'd0);
        cycles(3);
        i_enable = 1'b1;
        cycles(3);
        push(8'h01);
        tx_watch(10'b10_0000_0010, "01");
        cycles(4);

        // reset mid-RX frame (data all ones keeps the line quiet afterwards)
        i_line_in = 1'b0;
        cycles(B);
        i_line_in = 1'b1;
        cycles(2*B);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        chk("midrst_valid", {31'd0, o_rx_valid}, 32'd0);
        chk("midrst_oe",    {31'd0, o_line_oe},  32'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        cycles(10*B);
        expect_rx(8'h96);
        send_frame(8'h96, 1'b1);
        chk("rx_all_delivered", exp_rd, exp_wr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic send_frame_checked();
        expect_rx(8'h3C);
        send_frame(8'h3C, 1'b1);
        chk("rx_3c_delivered", exp_rd, 32'd1);
        i_line_in = 1'b0;
        cycles(5);
        i_line_in = 1'b1;
        cycles(3*B);
        chk("glitch_no_byte", exp_rd, 32'd1);
        chk("glitch_valid", {31'd0, o_rx_valid}, 32'd0);
    endtask

endmodule
